// File: rtl/uart_game_decoder.sv
// uart_game_decoder
//   Pulls 4-byte game-state packets out of a UART receive FIFO and keeps the
//   most recent value of every remote field. Header byte = {0, type[2:0], 0000},
//   followed by three payload bytes D1..D3 forming data[23:0] (D1 is the MSB).
//   Bad headers are dropped one byte at a time to resynchronise, and a stalled
//   packet is abandoned after TIMEOUT_CYCLES idle clocks.
//
// Ports
//   clk               system clock, all logic on the rising edge
//   rst               synchronous active-low reset
//   rx_data           FIFO head byte, valid while rx_empty = 0
//   rx_empty          FIFO empty flag
//   rd_uart           combinational pop strobe (byte consumed at this edge)
//   remote_char_x/y   character position        (type 000)
//   remote_char_hp    character HP              (type 001)
//   remote_boss_x/y   boss position             (type 010)
//   remote_boss_hp    boss HP                   (type 011)
//   remote_on_ground  on-ground status          (type 100)
//   pkt_valid         one-cycle pulse per committed packet
//   pkt_type          type of the last committed packet
//   pkt_error         one-cycle pulse on bad header or timeout
//   err_count         saturating error counter
module uart_game_decoder #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 500000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] rx_data,
    input  logic                  rx_empty,
    output logic                  rd_uart,
    output logic [11:0]           remote_char_x,
    output logic [11:0]           remote_char_y,
    output logic [3:0]            remote_char_hp,
    output logic [11:0]           remote_boss_x,
    output logic [11:0]           remote_boss_y,
    output logic [6:0]            remote_boss_hp,
    output logic                  remote_on_ground,
    output logic                  pkt_valid,
    output logic [2:0]            pkt_type,
    output logic                  pkt_error,
    output logic [7:0]            err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, DATA1, DATA2, DATA3, COMMIT} state_t;

    state_t        state, state_next;
    logic [TW-1:0] timer;
    logic [2:0]    type_q;
    logic [23:0]   payload;

    logic          in_data;
    logic          header_ok;
    logic          timeout_hit;
    logic          commit;
    logic          err_event;

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    // NOTE: every clocked process uses <= so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    // NOTE: state_next gets a default before the case so no path infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (rd_uart && header_ok) state_next = DATA1;
            DATA1:   if (rd_uart) state_next = DATA2; else if (timeout_hit) state_next = IDLE;
            DATA2:   if (rd_uart) state_next = DATA3; else if (timeout_hit) state_next = IDLE;
            DATA3:   if (rd_uart) state_next = COMMIT; else if (timeout_hit) state_next = IDLE;
            COMMIT:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Output / control decode
    // ---------------------------------------------------------------------
    always_comb begin
        in_data     = (state == DATA1) || (state == DATA2) || (state == DATA3);
        // Never pop while empty, while in reset, or during the commit cycle.
        rd_uart     = rst && !rx_empty && (state != COMMIT);
        header_ok   = !rx_data[7] && (rx_data[3:0] == 4'h0) && (rx_data[6:4] <= 3'd4);
        // Fires on the clock where the idle count would reach TIMEOUT_CYCLES.
        timeout_hit = in_data && rx_empty && (timer == TW'(TIMEOUT_CYCLES - 1));
        commit      = (state == COMMIT);
        err_event   = ((state == IDLE) && rd_uart && !header_ok) || timeout_hit;
    end

    // ---------------------------------------------------------------------
    // Packet assembly registers
    // ---------------------------------------------------------------------
    // NOTE: type_q and payload carry no reset: each is written by the packet
    // that later reads it, so a reset value would never be observed.
    always_ff @(posedge clk) begin
        if (state == IDLE && rd_uart && header_ok) type_q <= rx_data[6:4];
        if (rd_uart) begin
            case (state)
                DATA1:   payload[23:16] <= rx_data[7:0];
                DATA2:   payload[15:8]  <= rx_data[7:0];
                DATA3:   payload[7:0]   <= rx_data[7:0];
                default: ;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Timeout counter, status pulses, committed fields
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            timer            <= '0;
            pkt_valid        <= 1'b0;
            pkt_error        <= 1'b0;
            err_count        <= 8'd0;
            pkt_type         <= 3'd0;
            remote_char_x    <= 12'd0;
            remote_char_y    <= 12'd0;
            remote_char_hp   <= 4'd0;
            remote_boss_x    <= 12'd0;
            remote_boss_y    <= 12'd0;
            remote_boss_hp   <= 7'd0;
            remote_on_ground <= 1'b0;
        end else begin
            // A pop in DATAn implies rx_empty = 0, so the count clears there too.
            if (in_data && rx_empty && !timeout_hit) timer <= timer + 1'b1;
            else                                    timer <= '0;

            pkt_valid <= commit;
            pkt_error <= err_event;
            if (err_event && err_count != 8'hFF) err_count <= err_count + 8'd1;

            if (commit) begin
                pkt_type <= type_q;
                case (type_q)
                    3'd0: begin
                        remote_char_x <= payload[23:12];
                        remote_char_y <= payload[11:0];
                    end
                    3'd1: remote_char_hp <= payload[3:0];
                    3'd2: begin
                        remote_boss_x <= payload[23:12];
                        remote_boss_y <= payload[11:0];
                    end
                    3'd3: remote_boss_hp   <= payload[6:0];
                    3'd4: remote_on_ground <= payload[0];
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: doc/uart_game_decoder.md
UART_GAME_DECODER -- requirements
Module: uart_game_decoder

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, UART byte width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 500000, max idle clocks allowed between bytes of one packet.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-low reset (0 = reset, sampled on clk).
REQ-005 SHALL have port rx_data  input  DATA_WIDTH  head byte of the receive FIFO, valid whenever rx_empty=0.
REQ-006 SHALL have port rx_empty  input  1  receive FIFO empty.
REQ-007 SHALL have port rd_uart  output  1  combinational pop strobe; the byte on rx_data is consumed at the edge where rd_uart=1.
REQ-008 SHALL have ports remote_char_x, remote_char_y  output  12 each  last received character position.
REQ-009 SHALL have port remote_char_hp  output  4  last received character HP.
REQ-010 SHALL have ports remote_boss_x, remote_boss_y  output  12 each  last received boss position.
REQ-011 SHALL have port remote_boss_hp  output  7  last received boss HP.
REQ-012 SHALL have port remote_on_ground  output  1  last received on_ground status.
REQ-013 SHALL have port pkt_valid  output  1  one-cycle pulse when a packet is committed.
REQ-014 SHALL have port pkt_type  output  3  type of the last committed packet.
REQ-015 SHALL have port pkt_error  output  1  one-cycle pulse on a bad header or a timeout.
REQ-016 SHALL have port err_count  output  8  saturating error counter.

Function
REQ-017 Packet SHALL be 4 bytes: header {0,type[2:0],0000}, then D1=data[23:16], D2=data[15:8], D3=data[7:0].
REQ-018 Types SHALL be: 000 char pos {x[11:0],y[11:0]}; 001 char hp = data[3:0]; 010 boss pos {x,y}; 011 boss hp = data[6:0]; 100 status on_ground = data[0]; 101-111 invalid.
REQ-019 FSM states SHALL be IDLE, DATA1, DATA2, DATA3, COMMIT.
REQ-020 rd_uart SHALL equal !rx_empty in IDLE, DATA1, DATA2 and DATA3, and SHALL be 0 in COMMIT; the FIFO is never popped while empty.
REQ-021 IDLE: a popped byte with bit7=0, bits[3:0]=0 and type<=100 SHALL latch the type and go to DATA1.
REQ-022 IDLE: any other popped byte SHALL be dropped, SHALL pulse pkt_error the next cycle, and the FSM SHALL stay in IDLE (resynchronisation).
REQ-023 DATAn: a popped byte SHALL be stored into its 24-bit slot and the FSM SHALL advance (DATA1->DATA2->DATA3->COMMIT); payload bytes are never checked for header format.
REQ-024 COMMIT SHALL last exactly one cycle: only the field(s) of the latched type are updated, pkt_type is updated, pkt_valid=1, then the FSM returns to IDLE.
REQ-025 Latency: outputs and pkt_valid SHALL change exactly 1 edge after the edge that pops D3.
REQ-026 Max throughput SHALL be one packet per 5 cycles; back-to-back bytes SHALL be accepted with no stall except in COMMIT.
REQ-027 Timeout counter SHALL reset to 0 on every pop and whenever in IDLE, and SHALL increment each cycle in DATA1-3 with rx_empty=1.
REQ-028 When the counter reaches TIMEOUT_CYCLES, the partial packet SHALL be discarded, outputs unchanged, pkt_error pulsed, and the FSM sent to IDLE.
REQ-029 err_count SHALL increment once per pkt_error pulse and saturate at 255 (no wrap).
REQ-030 Fields not addressed by a packet SHALL hold their value indefinitely.

Reset
REQ-031 rst=0 at a clk edge SHALL force state IDLE, timeout counter 0, all remote_* outputs 0, pkt_type 000, pkt_valid 0, pkt_error 0, err_count 0.
REQ-032 Reset mid-packet SHALL discard the partial packet; the first byte after release SHALL be parsed as a header.
REQ-033 rd_uart SHALL be 0 while rst=0.

Verification
REQ-034 Bytes 00,12,34,56 back-to-back -> remote_char_x=0x123, remote_char_y=0x456, pkt_type=000, pkt_valid one cycle, 1 cycle after the D3 pop.
REQ-035 Bytes 30,00,00,55 -> remote_boss_hp=0x55; char and position fields unchanged.
REQ-036 Bytes 7F then 10,00,00,09 -> pkt_error pulse, err_count=1; 7F dropped; remote_char_hp=9.
REQ-037 Bytes 20,01 then FIFO empty for TIMEOUT_CYCLES -> pkt_error, FSM in IDLE, boss pos unchanged; next 40,00,00,01 -> remote_on_ground=1.
REQ-038 Assert rst=0 after 00,AB -> all outputs 0; after release 10,00,00,03 -> remote_char_hp=3.
REQ-039 Force 300 bad headers -> err_count=255, no wrap; verify rd_uart never high while rx_empty=1.
